// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button level into click / double-click / long-press events
//
// Purpose:
//   Watches the debounced, clk-synchronous button level and reports user gestures.
//   A press shorter than LONG_CYCLES followed by a gap of GAP_CYCLES lows is a single
//   click. A re-press inside the gap turns it into a double click, reported when the
//   second press is released. A press held for LONG_CYCLES is a long press, and
//   long_held then stays up until the release is sampled.
//
// Ports:
//   clk            in   system clock, all logic on the rising edge
//   rst_n          in   synchronous reset, active low
//   button_pressed in   debounced button level, 1 = pressed
//   single_click   out  one-cycle pulse, single click recognised
//   double_click   out  one-cycle pulse, double click recognised
//   long_press     out  one-cycle pulse, long-press threshold reached
//   long_held      out  level, high from long_press until release is sampled
//   busy           out  level, gesture in progress (FSM not idle)

module button_event_decoder #(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_pressed,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic long_held,
  output logic busy
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] LONG_CNT = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] GAP_CNT  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    LONG_HELD = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          prev_q;
  logic          single_q;
  logic          double_q;
  logic          long_q;
  logic          held_q;
  logic          busy_q;

  // cnt_d is the count including the sample being taken on this edge, so a
  // compare against it fires on the edge that samples the N-th level.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      // Treat the pre-reset level as high so a button held through reset
      // release is not seen as a fresh press.
      prev_q   <= 1'b1;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      prev_q   <= button_pressed;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (button_pressed && !prev_q) begin
            state_q <= PRESS1;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end

        PRESS1: begin
          if (button_pressed) begin
            cnt_q <= cnt_d;
            if (cnt_d == LONG_CNT) begin
              long_q  <= 1'b1;
              held_q  <= 1'b1;
              state_q <= LONG_HELD;
            end
          end else begin
            state_q <= WAIT_GAP;
            cnt_q   <= CNT_ONE;
          end
        end

        WAIT_GAP: begin
          // A re-press wins over gap expiry when both land on the same edge.
          if (button_pressed) begin
            state_q <= PRESS2;
          end else if (cnt_d == GAP_CNT) begin
            single_q <= 1'b1;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        PRESS2: begin
          if (!button_pressed) begin
            double_q <= 1'b1;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
        end

        LONG_HELD: begin
          if (!button_pressed) begin
            held_q  <= 1'b0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign single_click = single_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign long_held    = held_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - self-checking bench for button_event_decoder

module tb_button_event_decoder;

  localparam int L    = 20;
  localparam int G    = 10;
  localparam int MAXN = 8000;

  logic clk = 1'b0;
  logic rst_n;
  logic button_pressed;
  logic single_click;
  logic double_click;
  logic long_press;
  logic long_held;
  logic busy;

  bit btn_a  [MAXN];
  bit rstn_a [MAXN];
  bit e_sc   [MAXN];
  bit e_dc   [MAXN];
  bit e_lp   [MAXN];
  bit e_lh   [MAXN];
  bit e_busy [MAXN];

  int n      = 0;
  int checks = 0;
  int fails  = 0;

  button_event_decoder #(
    .LONG_CYCLES (L),
    .GAP_CYCLES  (G)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .button_pressed (button_pressed),
    .single_click   (single_click),
    .double_click   (double_click),
    .long_press     (long_press),
    .long_held      (long_held),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic push(input bit lvl, input bit rn, input int len);
    for (int k = 0; k < len; k++) begin
      if (n < MAXN) begin
        btn_a[n]  = lvl;
        rstn_a[n] = rn;
        n++;
      end
    end
  endtask

  function automatic int run_len(input int p, input bit lvl, input int lim);
    int q;
    q = p;
    while (q < lim && btn_a[q] == lvl) q++;
    return q - p;
  endfunction

  task automatic set_busy(input int a, input int b);
    for (int k = a; k < b; k++) e_busy[k] = 1'b1;
  endtask

  // Reference model: reads the stimulus as runs of highs and lows inside one
  // reset-free region and applies the gesture rules to the run lengths.
  task automatic parse_region(input int r0, input int r1);
    int pos, t, h1, s, g, h2s, h2, e;
    pos = r0;
    pos += run_len(pos, 1'b1, r1);  // level held through reset is not a press
    while (pos < r1) begin
      pos += run_len(pos, 1'b0, r1);
      if (pos >= r1) break;
      t  = pos;
      h1 = run_len(t, 1'b1, r1);
      if (h1 >= L) begin
        e_lp[t+L-1] = 1'b1;
        for (int k = t + L - 1; k < t + h1; k++) e_lh[k] = 1'b1;
        set_busy(t, t + h1);
        pos = t + h1;
      end else begin
        s = t + h1;
        if (s >= r1) begin set_busy(t, r1); break; end
        g = run_len(s, 1'b0, r1);
        if (g >= G) begin
          e_sc[s+G-1] = 1'b1;
          set_busy(t, s + G - 1);
          pos = s + G;
        end else begin
          h2s = s + g;
          if (h2s >= r1) begin set_busy(t, r1); break; end
          h2 = run_len(h2s, 1'b1, r1);
          e  = h2s + h2;
          if (e >= r1) begin set_busy(t, r1); break; end
          e_dc[e] = 1'b1;
          set_busy(t, e);
          pos = e;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int idx, input logic obs, input bit exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, idx, obs, exp);
    end
  endtask

  initial begin
    int i, r0;
    rst_n          = 1'b0;
    button_pressed = 1'b0;

    // reset, then idle
    push(1'b0, 1'b0, 3);
    push(1'b0, 1'b1, 3);
    // single click: press 5, release
    push(1'b1, 1'b1, 5);  push(1'b0, 1'b1, 15);
    // double click: press 5, low 4, press 5, release
    push(1'b1, 1'b1, 5);  push(1'b0, 1'b1, 4);
    push(1'b1, 1'b1, 5);  push(1'b0, 1'b1, 15);
    // long press held 30
    push(1'b1, 1'b1, 30); push(1'b0, 1'b1, 15);
    // just below long threshold
    push(1'b1, 1'b1, 19); push(1'b0, 1'b1, 15);
    // re-press on the 10th sample after release -> double
    push(1'b1, 1'b1, 3);  push(1'b0, 1'b1, 9);
    push(1'b1, 1'b1, 3);  push(1'b0, 1'b1, 15);
    // re-press on the 11th sample -> single, then a fresh press
    push(1'b1, 1'b1, 3);  push(1'b0, 1'b1, 10);
    push(1'b1, 1'b1, 4);  push(1'b0, 1'b1, 15);
    // reset mid-press while held, release, normal click
    push(1'b1, 1'b1, 5);  push(1'b1, 1'b0, 3);
    push(1'b1, 1'b1, 6);  push(1'b0, 1'b1, 3);
    push(1'b1, 1'b1, 5);  push(1'b0, 1'b1, 15);
    // one-cycle press
    push(1'b1, 1'b1, 1);  push(1'b0, 1'b1, 15);
    // exactly-long press and one-cycle double
    push(1'b1, 1'b1, 20); push(1'b0, 1'b1, 12);
    push(1'b1, 1'b1, 1);  push(1'b0, 1'b1, 1);
    push(1'b1, 1'b1, 1);  push(1'b0, 1'b1, 15);

    // randomized gestures around the thresholds
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0)
        push(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 4));
      push(1'b1, 1'b1, $urandom_range(1, 24));
      push(1'b0, 1'b1, $urandom_range(1, 13));
    end
    push(1'b0, 1'b1, 15);

    i = 0;
    while (i < n) begin
      if (!rstn_a[i]) begin
        i++;
      end else begin
        r0 = i;
        while (i < n && rstn_a[i]) i++;
        parse_region(r0, i);
      end
    end

    for (int c = 0; c < n; c++) begin
      button_pressed = btn_a[c];
      rst_n          = rstn_a[c];
      @(posedge clk);
      #1;
      chk("single_click", c, single_click, e_sc[c]);
      chk("double_click", c, double_click, e_dc[c]);
      chk("long_press",   c, long_press,   e_lp[c]);
      chk("long_held",    c, long_held,    e_lh[c]);
      chk("busy",         c, busy,         e_busy[c]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
